// File: rtl/stochastic_run_controller_if.sv
// Operand, stochastic-bit and result handshake bus of the stochastic run controller.
// The master side is the environment; the slave side is the controller.
interface stochastic_run_controller_if;
   logic       start;
   logic       abort;
   logic [1:0] op_sel;
   logic       ser_a;
   logic       ser_b;
   logic       sn_bit;
   logic [8:0] operand_a;
   logic [8:0] operand_b;
   logic       run_en;
   logic       busy;
   logic [8:0] result;
   logic       result_valid;
   logic       result_ready;

   modport master (
      output start, abort, op_sel, ser_a, ser_b, sn_bit, result_ready,
      input  operand_a, operand_b, run_en, busy, result, result_valid
   );

   modport slave (
      input  start, abort, op_sel, ser_a, ser_b, sn_bit, result_ready,
      output operand_a, operand_b, run_en, busy, result, result_valid
   );
endinterface

// File: rtl/stochastic_run_controller.sv
// Run controller for a stochastic arithmetic unit: loads two serial 9-bit operands,
// counts ones over a 2^WIN_LOG2 window and returns a scaled 9-bit probability.
module stochastic_run_controller #(
   parameter int WIN_LOG2  = 17,
   parameter int FRAME_LEN = 10
) (
   input  logic                        clk,
   input  logic                        rst_n,
   stochastic_run_controller_if.slave  bus
);
   localparam int             FCW        = $clog2(FRAME_LEN + 1);
   localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_LEN - 1);
   localparam logic [FCW-1:0] DATA_BITS  = FCW'(9);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

   state_t              state_q, state_d;
   logic [1:0]          op_q, op_d;
   logic [FCW-1:0]      frame_q, frame_d;
   logic [8:0]          sh_a_q, sh_a_d, sh_b_q, sh_b_d;
   logic [8:0]          opa_q, opa_d, opb_q, opb_d;
   logic [WIN_LOG2-1:0] win_q, win_d;
   logic [WIN_LOG2:0]   ones_q, ones_d;
   logic [WIN_LOG2:0]   ones_final;
   logic [8:0]          result_q, result_d;

   // Self-multiply keeps the low bits; the others keep the top nine window bits.
   function automatic logic [8:0] scale_count(input logic [1:0] op, input logic [WIN_LOG2:0] cnt);
      logic [8:0] r;
      if (op == 2'b10) begin
         r = (|cnt[WIN_LOG2:9]) ? 9'h1FF : cnt[8:0];
      end else begin
         r = cnt[WIN_LOG2] ? 9'h1FF : cnt[WIN_LOG2-1 -: 9];
      end
      return r;
   endfunction

   assign ones_final = ones_q + {{WIN_LOG2{1'b0}}, bus.sn_bit};

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      frame_d  = frame_q;
      sh_a_d   = sh_a_q;
      sh_b_d   = sh_b_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      win_d    = win_q;
      ones_d   = ones_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               op_d    = bus.op_sel;
               frame_d = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (frame_q < DATA_BITS) begin
               sh_a_d = {bus.ser_a, sh_a_q[8:1]};
               sh_b_d = {bus.ser_b, sh_b_q[8:1]};
            end
            if (frame_q == FRAME_LAST) begin
               opa_d   = sh_a_d;
               opb_d   = sh_b_d;
               frame_d = '0;
               win_d   = '0;
               ones_d  = '0;
               state_d = RUN;
            end else begin
               frame_d = frame_q + FCW'(1);
            end
         end
         RUN: begin
            ones_d = ones_final;
            win_d  = win_q + WIN_LOG2'(1);
            if (&win_q) begin
               result_d = scale_count(op_q, ones_final);
               win_d    = '0;
               ones_d   = '0;
               state_d  = HOLD;
            end
         end
         HOLD: begin
            if (bus.result_ready) begin
               state_d = IDLE;
            end
         end
      endcase
      // Abort abandons the operation without touching operands or the last result.
      if (bus.abort && state_q != IDLE) begin
         state_d  = IDLE;
         frame_d  = '0;
         win_d    = '0;
         ones_d   = '0;
         opa_d    = opa_q;
         opb_d    = opb_q;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= '0;
         frame_q  <= '0;
         sh_a_q   <= '0;
         sh_b_q   <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         win_q    <= '0;
         ones_q   <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         frame_q  <= frame_d;
         sh_a_q   <= sh_a_d;
         sh_b_q   <= sh_b_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         win_q    <= win_d;
         ones_q   <= ones_d;
         result_q <= result_d;
      end
   end

   assign bus.operand_a    = opa_q;
   assign bus.operand_b    = opb_q;
   assign bus.run_en       = (state_q == RUN);
   assign bus.busy         = (state_q != IDLE);
   assign bus.result       = result_q;
   assign bus.result_valid = (state_q == HOLD);
endmodule

// File: tb/tb_stochastic_run_controller.sv
// Randomized bench for stochastic_run_controller against a cycle-indexed reference
// of the load/run/hold timeline and the count scaling rules.
module tb_stochastic_run_controller;
   localparam int W    = 9;
   localparam int FL   = 10;
   localparam int NWIN = 1 << W;
   localparam int LAT  = 1 + FL + NWIN;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [8:0] m_opa, m_opb, m_res;

   int         o_lat, o_run_cycles, o_load_bad, o_busy_bad, o_hold_bad, e_count;
   logic [8:0] o_opa, o_opb, o_res, e_res;

   stochastic_run_controller_if bus();

   stochastic_run_controller #(.WIN_LOG2(W), .FRAME_LEN(FL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [8:0] ref_result(input logic [1:0] op, input int cnt);
      if (op == 2'b10) return (cnt > 511) ? 9'd511 : 9'(cnt);
      if (cnt >= NWIN) return 9'd511;
      return 9'(cnt / (NWIN / 512));
   endfunction

   function automatic bit sn_pattern(input int mode, input int param, input int j);
      case (mode)
         0:       return 1'b1;
         1:       return (j % 2) == 0;
         2:       return j < param;
         default: return int'($urandom_range(99)) < param;
      endcase
   endfunction

   // Drives one full evaluation; slot c is the cycle c after the start cycle.
   task automatic drive_run(input logic [1:0] op, input logic [8:0] a, input logic [8:0] b,
                            input int mode, input int param, input int hold_len);
      bit s;
      o_lat = -1; o_run_cycles = 0; o_load_bad = 0; o_busy_bad = 0; o_hold_bad = 0;
      e_count = 0; o_opa = '0; o_opb = '0;
      bus.start = 1'b1; bus.abort = 1'b0; bus.op_sel = op; bus.result_ready = 1'b0;
      bus.ser_a = 1'($urandom); bus.ser_b = 1'($urandom); bus.sn_bit = 1'($urandom);
      step();
      for (int c = 1; c <= LAT + 20; c++) begin
         if (bus.result_valid) begin
            o_lat = c;
            break;
         end
         if (bus.run_en) o_run_cycles++;
         if (!bus.busy) o_busy_bad++;
         if (c <= FL && (bus.operand_a !== m_opa || bus.operand_b !== m_opb)) o_load_bad++;
         if (c == FL + 1) begin
            o_opa = bus.operand_a;
            o_opb = bus.operand_b;
         end
         bus.start        = 1'($urandom);
         bus.op_sel       = 2'($urandom);
         bus.result_ready = 1'($urandom);
         bus.ser_a = (c <= 9) ? a[c-1] : 1'($urandom);
         bus.ser_b = (c <= 9) ? b[c-1] : 1'($urandom);
         if (c >= FL + 1 && c <= FL + NWIN) begin
            s = sn_pattern(mode, param, c - FL - 1);
            e_count += int'(s);
            bus.sn_bit = s;
         end else begin
            bus.sn_bit = 1'($urandom);
         end
         step();
      end
      e_res = ref_result(op, e_count);
      o_res = bus.result;
      bus.result_ready = 1'b0;
      for (int h = 0; h < hold_len; h++) begin
         bus.start = 1'($urandom);
         step();
         if (!bus.result_valid || !bus.busy || bus.result !== e_res) o_hold_bad++;
      end
      bus.start = 1'b0;
      bus.result_ready = 1'b1;
      step();
      bus.result_ready = 1'b0;
      m_opa = a; m_opb = b; m_res = e_res;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.op_sel = 2'b00; bus.ser_a = 1'b0;
      bus.ser_b = 1'b0; bus.sn_bit = 1'b0; bus.result_ready = 1'b0;
      m_opa = '0; m_opb = '0; m_res = '0;
      #12;
      n_cmp++; if (bus.operand_a !== 9'h000) begin n_bad++; $display("FAIL reset_opa got %h want 000", bus.operand_a); end
      n_cmp++; if (bus.operand_b !== 9'h000) begin n_bad++; $display("FAIL reset_opb got %h want 000", bus.operand_b); end
      n_cmp++; if (bus.result !== 9'h000) begin n_bad++; $display("FAIL reset_result got %h want 000", bus.result); end
      n_cmp++; if ({bus.run_en, bus.busy, bus.result_valid} !== 3'b000) begin
         n_bad++; $display("FAIL reset_flags got %b want 000", {bus.run_en, bus.busy, bus.result_valid}); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      drive_run(2'b00, 9'h155, 9'h0AA, 0, 0, 3);
      n_cmp++; if (o_lat !== LAT) begin n_bad++; $display("FAIL basic_latency got %0d want %0d", o_lat, LAT); end
      n_cmp++; if (o_run_cycles !== NWIN) begin n_bad++; $display("FAIL basic_run_en_cycles got %0d want %0d", o_run_cycles, NWIN); end
      n_cmp++; if (o_opa !== 9'h155) begin n_bad++; $display("FAIL basic_operand_a got %h want 155", o_opa); end
      n_cmp++; if (o_opb !== 9'h0AA) begin n_bad++; $display("FAIL basic_operand_b got %h want 0aa", o_opb); end
      n_cmp++; if (o_load_bad !== 0) begin n_bad++; $display("FAIL basic_operand_hold_in_load got %0d changes want 0", o_load_bad); end
      n_cmp++; if (o_busy_bad !== 0) begin n_bad++; $display("FAIL basic_busy got %0d idle cycles want 0", o_busy_bad); end
      n_cmp++; if (o_res !== 9'd511) begin n_bad++; $display("FAIL basic_result got %0d want 511", o_res); end
      n_cmp++; if (o_hold_bad !== 0) begin n_bad++; $display("FAIL basic_hold got %0d bad cycles want 0", o_hold_bad); end
      n_cmp++; if ({bus.busy, bus.result_valid} !== 2'b00 || bus.result !== 9'd511) begin
         n_bad++; $display("FAIL basic_release got busy/valid %b result %0d want 00 511",
                           {bus.busy, bus.result_valid}, bus.result); end
   endtask

   task automatic test_alternate();
      drive_run(2'b01, 9'($urandom), 9'($urandom), 1, 0, 1);
      n_cmp++; if (o_res !== 9'd256) begin n_bad++; $display("FAIL alternate_result got %0d want 256", o_res); end
      n_cmp++; if (o_lat !== LAT) begin n_bad++; $display("FAIL alternate_latency got %0d want %0d", o_lat, LAT); end
   endtask

   task automatic test_self_mul();
      drive_run(2'b10, 9'($urandom), 9'($urandom), 2, 37, 0);
      n_cmp++; if (o_res !== 9'd37) begin n_bad++; $display("FAIL self_mul_37 got %0d want 37", o_res); end
      drive_run(2'b10, 9'($urandom), 9'($urandom), 0, 0, 0);
      n_cmp++; if (o_res !== 9'd511) begin n_bad++; $display("FAIL self_mul_sat got %0d want 511", o_res); end
      drive_run(2'b11, 9'($urandom), 9'($urandom), 2, 300, 0);
      n_cmp++; if (o_res !== 9'd300) begin n_bad++; $display("FAIL op11_as_op00 got %0d want 300", o_res); end
   endtask

   task automatic test_abort_idle();
      int busy_seen = 0;
      bus.start = 1'b1; bus.abort = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         if (bus.busy) busy_seen++;
      end
      bus.start = 1'b0; bus.abort = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (bus.busy) busy_seen++;
      end
      n_cmp++; if (busy_seen !== 0) begin n_bad++; $display("FAIL abort_idle got %0d busy cycles want 0", busy_seen); end
   endtask

   task automatic test_abort_run();
      logic [8:0] a, b;
      int hi_seen = 0;
      a = 9'($urandom); b = 9'($urandom);
      bus.start = 1'b1; bus.op_sel = 2'b00;
      step();
      bus.start = 1'b0;
      for (int c = 1; c <= FL + 100; c++) begin
         bus.ser_a = (c <= 9) ? a[c-1] : 1'($urandom);
         bus.ser_b = (c <= 9) ? b[c-1] : 1'($urandom);
         bus.sn_bit = 1'($urandom);
         step();
      end
      n_cmp++; if (bus.run_en !== 1'b1) begin n_bad++; $display("FAIL abort_run_pre got run_en %b want 1", bus.run_en); end
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      n_cmp++; if ({bus.run_en, bus.busy, bus.result_valid} !== 3'b000) begin
         n_bad++; $display("FAIL abort_run_flags got %b want 000", {bus.run_en, bus.busy, bus.result_valid}); end
      n_cmp++; if (bus.result !== m_res) begin n_bad++; $display("FAIL abort_run_result got %0d want %0d", bus.result, m_res); end
      n_cmp++; if (bus.operand_a !== a || bus.operand_b !== b) begin
         n_bad++; $display("FAIL abort_run_operands got %h/%h want %h/%h", bus.operand_a, bus.operand_b, a, b); end
      m_opa = a; m_opb = b;
      for (int c = 0; c < NWIN + 20; c++) begin
         bus.sn_bit = 1'($urandom);
         bus.result_ready = 1'($urandom);
         step();
         if (bus.result_valid || bus.run_en) hi_seen++;
      end
      bus.result_ready = 1'b0;
      n_cmp++; if (hi_seen !== 0) begin n_bad++; $display("FAIL abort_run_quiet got %0d active cycles want 0", hi_seen); end
   endtask

   task automatic test_hold_ready();
      drive_run(2'($urandom), 9'($urandom), 9'($urandom), 3, 60, 20);
      n_cmp++; if (o_hold_bad !== 0) begin n_bad++; $display("FAIL hold_stable got %0d bad cycles want 0", o_hold_bad); end
      n_cmp++; if (o_res !== e_res) begin n_bad++; $display("FAIL hold_result got %0d want %0d", o_res, e_res); end
      n_cmp++; if ({bus.busy, bus.result_valid} !== 2'b00) begin
         n_bad++; $display("FAIL hold_release got %b want 00", {bus.busy, bus.result_valid}); end
   endtask

   task automatic test_random();
      logic [8:0] a, b;
      for (int i = 0; i < 5; i++) begin
         a = 9'($urandom); b = 9'($urandom);
         drive_run(2'($urandom), a, b, 3, int'($urandom_range(100)), int'($urandom_range(5)));
         n_cmp++; if (o_res !== e_res) begin n_bad++; $display("FAIL random_result[%0d] got %0d want %0d", i, o_res, e_res); end
         n_cmp++; if (o_opa !== a || o_opb !== b) begin
            n_bad++; $display("FAIL random_operands[%0d] got %h/%h want %h/%h", i, o_opa, o_opb, a, b); end
      end
   endtask

   task automatic test_reset_load();
      int run_seen = 0;
      bus.start = 1'b1; bus.op_sel = 2'b00;
      step();
      bus.start = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         bus.ser_a = 1'($urandom); bus.ser_b = 1'($urandom);
         step();
      end
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({bus.operand_a, bus.operand_b, bus.result} !== 27'd0) begin
         n_bad++; $display("FAIL reset_load_data got %h/%h/%h want 0/0/0", bus.operand_a, bus.operand_b, bus.result); end
      n_cmp++; if ({bus.run_en, bus.busy, bus.result_valid} !== 3'b000) begin
         n_bad++; $display("FAIL reset_load_flags got %b want 000", {bus.run_en, bus.busy, bus.result_valid}); end
      m_opa = '0; m_opb = '0; m_res = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < NWIN + 20; c++) begin
         step();
         if (bus.run_en || bus.busy) run_seen++;
      end
      n_cmp++; if (run_seen !== 0) begin n_bad++; $display("FAIL reset_load_quiet got %0d active cycles want 0", run_seen); end
   endtask

   task automatic test_back_to_back();
      logic [8:0] r1;
      drive_run(2'b10, 9'($urandom), 9'($urandom), 2, 123, 0);
      r1 = o_res;
      drive_run(2'b00, 9'($urandom), 9'($urandom), 1, 0, 0);
      n_cmp++; if (r1 !== 9'd123) begin n_bad++; $display("FAIL b2b_first got %0d want 123", r1); end
      n_cmp++; if (o_res !== 9'd256 || o_lat !== LAT) begin
         n_bad++; $display("FAIL b2b_second got %0d lat %0d want 256 lat %0d", o_res, o_lat, LAT); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_alternate();
      test_self_mul();
      test_abort_idle();
      test_abort_run();
      test_hold_ready();
      test_random();
      test_reset_load();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/stochastic_run_controller.md
STOCHASTIC_RUN_CONTROLLER -- requirements
Module: stochastic_run_controller

Interface
REQ-001 Parameter WIN_LOG2, default 17: the evaluation window is 2^WIN_LOG2 clk cycles; the legal range is 9..17.
REQ-002 Parameter FRAME_LEN, default 10: serial operand frame length, made of 9 data bits plus 1 dummy bit.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request a new evaluation; sampled only in IDLE.
REQ-007 abort  input  1  synchronous cancel of any operation in progress.
REQ-008 op_sel  input  2  00 multiply, 01 add, 10 self-multiply, 11 reserved (treated as 00); latched on start.
REQ-009 ser_a  input  1  serial operand A, LSB first.
REQ-010 ser_b  input  1  serial operand B, LSB first.
REQ-011 sn_bit  input  1  stochastic output bit from the selected datapath, valid while run_en=1.
REQ-012 operand_a  output  9  latched operand A, driven to the SN generators.
REQ-013 operand_b  output  9  latched operand B, driven to the SN generators.
REQ-014 run_en  output  1  high for exactly 2^WIN_LOG2 cycles per evaluation.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 result  output  9  scaled probability count.
REQ-017 result_valid  output  1  result available.
REQ-018 result_ready  input  1  consumer accepts the result.

Function
REQ-019 The FSM SHALL have four states, IDLE, LOAD, RUN and HOLD, held in a registered state register.
REQ-020 IDLE: when start=1 and abort=0, latch op_sel, clear the frame counter and go to LOAD on the next edge.
REQ-021 LOAD lasts exactly FRAME_LEN cycles; bit k of ser_a/ser_b, sampled in LOAD cycle k (k=0..8), SHALL land in operand_a[k]/operand_b[k].
REQ-022 In LOAD cycle 9 the dummy bit SHALL be discarded, then the FSM goes to RUN.
REQ-023 operand_a and operand_b SHALL update only on the transition LOAD->RUN; they hold their values in every other state, including after abort.
REQ-024 RUN: run_en=1, the window counter counts 0..2^WIN_LOG2-1, and the ones-counter increments on every cycle where sn_bit=1.
REQ-025 The ones-counter SHALL be WIN_LOG2+1 bits wide so that an all-ones window (count 2^WIN_LOG2) does not wrap.
REQ-026 On the last RUN cycle, the sn_bit of that same cycle SHALL be included in the count; the result is computed and the FSM goes to HOLD; run_en falls on the next edge.
REQ-027 Scaling for op 00/01/11: result = count[WIN_LOG2-1:WIN_LOG2-9]; if count = 2^WIN_LOG2, result = 511.
REQ-028 Scaling for op 10: result = count[8:0]; if count > 511, result = 511.
REQ-029 HOLD: result_valid=1 and result is stable; when result_valid and result_ready are both 1 on an edge, go to IDLE and result_valid falls.
REQ-030 result SHALL retain its last value in IDLE; result_valid=1 only in HOLD.
REQ-031 abort=1 in LOAD, RUN or HOLD: go to IDLE on the next edge, clear the counters, drive run_en=0 and result_valid=0, and do not update result.
REQ-032 abort=1 together with start=1 in IDLE: abort wins and the FSM stays in IDLE.
REQ-033 start outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-034 result_ready outside HOLD SHALL be ignored.
REQ-035 Latency from start to result_valid SHALL be 1 + FRAME_LEN + 2^WIN_LOG2 cycles.

Reset
REQ-036 With rst_n=0, outputs SHALL go asynchronously to: state IDLE, operand_a=0, operand_b=0, result=0, run_en=0, busy=0, result_valid=0, all counters 0.
REQ-037 Reset asserted mid-LOAD or mid-RUN SHALL abandon the operation; after rst_n rises the block waits in IDLE for a fresh start.
REQ-038 Deassertion is synchronous to clk by the integrator; the first edge after deassertion SHALL sample start normally.

Verification
REQ-039 WIN_LOG2=9, op 00, frames A=0x155, B=0x0AA, sn_bit tied to 1 -> operand_a=0x155, operand_b=0x0AA at RUN entry; run_en high for 512 cycles; result=511; result_valid at cycle 523.
REQ-040 WIN_LOG2=10, op 01, sn_bit high on every other RUN cycle -> count=512; result=256.
REQ-041 WIN_LOG2=9, op 10, sn_bit high for the first 37 RUN cycles -> result=37; repeat with all ones -> result=511 (saturated).
REQ-042 Abort in RUN cycle 100 -> IDLE next edge; run_en=0; result_valid never rises; result unchanged from the previous run.
REQ-043 HOLD with result_ready=0 for 20 cycles, then 1 -> result stable and valid throughout; IDLE one edge after ready; start during HOLD ignored.
REQ-044 rst_n pulsed low in LOAD cycle 5 -> all outputs 0 immediately; no RUN occurs until the next start.
